// File: rtl/dmem_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one data-memory port between two masters.
// Read data from the memory is captured into per-requester registers one cycle after the read beat.
module dmem_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic [AW-1:0] mem_A,
    output logic [DW-1:0] mem_WD,
    output logic          mem_WE,
    input  logic [DW-1:0] mem_RD
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_BURST);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           last_q, last_d;
    logic [1:0]     rvalid_q, rvalid_d;
    logic [1:0][DW-1:0] rdata_q, rdata_d;

    logic [1:0]     req, we, beat;
    logic           own_vld, own_idx;

    assign req     = {req1, req0};
    assign we      = {we1, we0};
    assign own_vld = (state_q != IDLE);
    assign own_idx = (state_q == OWN1);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req
            assign beat[gi]     = own_vld && (own_idx == 1'(gi)) && req[gi];
            assign rvalid_d[gi] = beat[gi] & ~we[gi];
            assign rdata_d[gi]  = rvalid_d[gi] ? mem_RD : rdata_q[gi];
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                // On a tie the requester not served most recently wins.
                if (req0 && req1)  state_d = last_q ? OWN0 : OWN1;
                else if (req0)     state_d = OWN0;
                else if (req1)     state_d = OWN1;
            end
            OWN0: begin
                if (!req0)                           state_d = req1 ? OWN1 : IDLE;
                else if (req1 && cnt_q >= CNT_LAST) state_d = OWN1;
            end
            OWN1: begin
                if (!req1)                           state_d = req0 ? OWN0 : IDLE;
                else if (req0 && cnt_q >= CNT_LAST) state_d = OWN0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d  = cnt_q;
        last_d = last_q;
        if (state_d != state_q) begin
            cnt_d = '0;
            if (state_d == OWN0) last_d = 1'b0;
            if (state_d == OWN1) last_d = 1'b1;
        end else if ((|beat) && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            last_q   <= 1'b1;
            rvalid_q <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    // The owner drives the address/data nets even on a dead cycle; only mem_WE is gated by the beat.
    assign mem_A   = !own_vld ? '0 : (own_idx ? addr1 : addr0);
    assign mem_WD  = !own_vld ? '0 : (own_idx ? wdata1 : wdata0);
    assign mem_WE  = |(beat & we);

    assign gnt0    = beat[0];
    assign gnt1    = beat[1];
    assign rvalid0 = rvalid_q[0];
    assign rvalid1 = rvalid_q[1];
    assign rdata0  = rdata_q[0];
    assign rdata1  = rdata_q[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus random traffic compared
// cycle by cycle against an owner/tenure reference model with a shadow memory.
module tb_dmem_arbiter;

    localparam int AW        = 32;
    localparam int DW        = 32;
    localparam int MAX_BURST = 4;

    logic          clk, rst;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1, mem_WE;
    logic [DW-1:0] rdata0, rdata1, mem_WD, mem_RD;
    logic [AW-1:0] mem_A;

    dmem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE), .mem_RD(mem_RD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory attached to the DUT, and the model's own copy of what it should hold.
    logic [DW-1:0] mem    [64];
    logic [DW-1:0] shadow [64];
    assign mem_RD = mem[mem_A[5:0]];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: who owns the port, how many beats this tenure, who was served last.
    int            m_owner;
    int            m_burst;
    int            m_last;
    logic          m_rv [2];
    logic [DW-1:0] m_rd [2];

    logic o_g0, o_g1, o_rv0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_burst = 0;
        m_last  = 1;
        m_rv[0] = 1'b0; m_rv[1] = 1'b0;
        m_rd[0] = '0;   m_rd[1] = '0;
    endtask

    task automatic drive(input logic r0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input logic r1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    endtask

    // Called just after a falling edge with inputs already driven; checks, then advances one clock.
    task automatic cycle();
        logic          r [2];
        logic          w [2];
        logic [AW-1:0] a [2];
        logic [DW-1:0] d [2];
        logic          eg0, eg1, ewe, beat, m_we;
        logic [AW-1:0] ea, m_a;
        logic [DW-1:0] ed, m_d;
        int            k, nxt;

        #2;
        r[0] = req0; r[1] = req1; w[0] = we0; w[1] = we1;
        a[0] = addr0; a[1] = addr1; d[0] = wdata0; d[1] = wdata1;
        k    = m_owner;
        eg0  = (k == 0) && r[0];
        eg1  = (k == 1) && r[1];
        beat = eg0 || eg1;
        ewe  = beat && w[k];
        ea   = (k < 0) ? '0 : a[k];
        ed   = (k < 0) ? '0 : d[k];

        chk("gnt0", gnt0, eg0);
        chk("gnt1", gnt1, eg1);
        chk("mem_WE", mem_WE, ewe);
        chk("mem_A", mem_A, ea);
        chk("mem_WD", mem_WD, ed);
        chk("rvalid0", rvalid0, m_rv[0]);
        chk("rvalid1", rvalid1, m_rv[1]);
        chk("rdata0", rdata0, m_rd[0]);
        chk("rdata1", rdata1, m_rd[1]);
        $display("cyc %0d req=%b%b gnt=%b%b we=%b A=%0h WD=%0h rv=%b%b rd0=%0h rd1=%0h",
                 cyc, req1, req0, gnt1, gnt0, mem_WE, mem_A, mem_WD, rvalid1, rvalid0, rdata0, rdata1);
        o_g0  = gnt0;
        o_g1  = gnt1;
        o_rv0 = rvalid0;
        m_we  = mem_WE;
        m_a   = mem_A;
        m_d   = mem_WD;

        // Next owner from the round-robin / burst-limit rules.
        if (k < 0)                                   nxt = (r[0] && r[1]) ? 1 - m_last : (r[0] ? 0 : (r[1] ? 1 : -1));
        else if (!r[k])                              nxt = r[1-k] ? 1 - k : -1;
        else if (r[1-k] && m_burst + 1 >= MAX_BURST) nxt = 1 - k;
        else                                         nxt = k;

        m_rv[0] = 1'b0;
        m_rv[1] = 1'b0;
        if (beat && !w[k]) begin
            m_rv[k] = 1'b1;
            m_rd[k] = shadow[a[k][5:0]];
        end
        if (beat && w[k]) shadow[a[k][5:0]] = d[k];
        if (nxt != k) begin
            m_burst = 0;
            if (nxt >= 0) m_last = nxt;
        end else if (beat) begin
            m_burst++;
        end
        m_owner = nxt;

        @(posedge clk);
        if (m_we) mem[m_a[5:0]] = m_d;
        @(negedge clk);
        cyc++;
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before any clock edge.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_gnt0", gnt0, 1'b0);
        chk("rst_gnt1", gnt1, 1'b0);
        chk("rst_we", mem_WE, 1'b0);
        chk("rst_rvalid0", rvalid0, 1'b0);
        chk("rst_rvalid1", rvalid1, 1'b0);
        chk("rst_rdata0", rdata0, '0);
        chk("rst_rdata1", rdata1, '0);
        model_reset();
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic g0h [20];
        logic g1h [20];
        int   prev, run, cur, dead, ovl, cnt_g, cnt_rv;

        for (int i = 0; i < 64; i++) begin
            mem[i]    = $urandom;
            shadow[i] = mem[i];
        end
        mem[6'h10]    = 32'hDEADBEEF;
        shadow[6'h10] = 32'hDEADBEEF;
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        rst = 1'b1;
        model_reset();
        #2;
        chk("init_gnt0", gnt0, 1'b0);
        chk("init_rvalid0", rvalid0, 1'b0);
        chk("init_rdata0", rdata0, '0);
        @(negedge clk);
        rst = 1'b0;

        // Single read from IDLE.
        drive(1, 0, 32'h10, '0, 0, 0, '0, '0);
        cycle();
        cycle();
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        cycle();
        chk("single_rd_data", rdata0, 32'hDEADBEEF);

        // First tie goes to 0, then 1 after 0 drops, and the next tie goes to 0 again.
        do_reset();
        drive(1, 0, 32'h1, '0, 1, 0, 32'h2, '0);
        cycle();
        cycle();
        drive(0, 0, '0, '0, 1, 0, 32'h2, '0);
        cycle();
        cycle();
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        cycle();
        cycle();
        drive(1, 0, 32'h3, '0, 1, 0, 32'h4, '0);
        cycle();
        cycle();
        chk("tie2_gnt0", o_g0, 1'b1);

        // Fairness: both requesting for 20 cycles.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(1, 0, AW'($urandom_range(0, 63)), '0, 1, 0, AW'($urandom_range(0, 63)), '0);
            cycle();
            g0h[i] = o_g0;
            g1h[i] = o_g1;
        end
        prev = -1; run = 0; dead = 0; ovl = 0;
        for (int i = 1; i < 20; i++) begin
            cur = g0h[i] ? 0 : (g1h[i] ? 1 : -1);
            if (g0h[i] && g1h[i]) ovl++;
            if (cur < 0) dead++;
            if (cur == prev) run++;
            else begin
                if (prev >= 0) chk("fair_run_len", run, MAX_BURST);
                prev = cur;
                run  = 1;
            end
        end
        chk("fair_dead", dead, 0);
        chk("fair_overlap", ovl, 0);

        // Write through requester 1, read back through requester 0.
        do_reset();
        drive(0, 0, '0, '0, 1, 1, 32'h20, 32'h12345678);
        cycle();
        cycle();
        drive(1, 0, 32'h20, '0, 0, 0, '0, '0);
        cycle();
        cycle();
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        cycle();
        chk("wr_rd_back", rdata0, 32'h12345678);

        // Lone streamer: ten reads at incrementing addresses.
        do_reset();
        cnt_g = 0; cnt_rv = 0;
        for (int i = 0; i < 12; i++) begin
            drive(i < 11, 0, AW'(32'h28 + (i > 0 ? i - 1 : 0)), '0, 0, 0, '0, '0);
            cycle();
            if (o_g0) cnt_g++;
            if (o_rv0) cnt_rv++;
        end
        chk("stream_gnt_count", cnt_g, 10);
        chk("stream_rvalid_count", cnt_rv, 10);

        // Reset during the second beat of a requester-1 tenure.
        do_reset();
        drive(0, 0, '0, '0, 1, 0, 32'h5, '0);
        cycle();
        cycle();
        drive(0, 0, '0, '0, 1, 0, 32'h6, '0);
        #2;
        chk("mid_pre_gnt1", gnt1, 1'b1);
        chk("mid_pre_rvalid1", rvalid1, 1'b1);
        do_reset();
        drive(1, 0, 32'h7, '0, 1, 0, 32'h8, '0);
        cycle();
        cycle();
        chk("post_rst_tie_gnt0", o_g0, 1'b1);

        // Random traffic.
        do_reset();
        for (int i = 0; i < 1000; i++) begin
            drive($urandom_range(0, 3) != 0, 1'($urandom), AW'($urandom_range(0, 63)), $urandom,
                  $urandom_range(0, 3) != 0, 1'($urandom), AW'($urandom_range(0, 63)), $urandom);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
